// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencer for the five-stage in-order backend.
// Produces stall/bubble/flush controls for R1..R4 from a memory handshake
// FSM, an optional multi-cycle mul/div occupancy FSM and hazard checks.
// Optional feature macro: PIPE_CTRL_MULDIV_EN (defined = mul/div FSM present;
// undefined = mul/div treated as single-cycle, md_busy/md_start tied low).
module pipe_ctrl #(
  parameter int LREG_W     = 5,
  parameter int MULDIV_LAT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [LREG_W-1:0] id_rs1,
  input  logic [LREG_W-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic              ex_valid,
  input  logic [LREG_W-1:0] ex_rd,
  input  logic              ex_is_load,
  input  logic              ex_is_muldiv,
  input  logic              redirect_valid,
  input  logic              mem_valid,
  input  logic              mem_is_load,
  input  logic              mem_is_store,
  input  logic              mem_req_ready,
  input  logic              mem_resp_valid,
  output logic              stall_r1,
  output logic              stall_r2,
  output logic              stall_r3,
  output logic              bubble_r2,
  output logic              bubble_r3,
  output logic              bubble_r4,
  output logic              flush_r1,
  output logic              redirect_fire,
  output logic              md_start,
  output logic              md_busy,
  output logic              mem_req_valid,
  output logic              mem_busy
);

  // ------------------------------------------------------------------
  // Memory handshake FSM
  // ------------------------------------------------------------------
  typedef enum logic [1:0] {M_IDLE, M_REQ, M_WAIT} mem_state_t;

  mem_state_t mem_state_reg, mem_state_next;
  logic       mem_op;
  logic       mem_req_int;
  logic       mem_complete;
  logic       mem_busy_int;

  assign mem_op = mem_valid & (mem_is_load | mem_is_store);

  // Memory FSM state register
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_state_reg <= M_IDLE;
    end else begin
      mem_state_reg <= mem_state_next;
    end
  end

  // Memory FSM next state, request and completion; a store finishes on
  // accept, a load finishes when its response arrives in M_WAIT
  always_comb begin
    mem_state_next = mem_state_reg;
    mem_req_int    = 1'b0;
    mem_complete   = 1'b0;
    case (mem_state_reg)
      M_IDLE: begin
        if (mem_op) begin
          mem_req_int = 1'b1;
          if (mem_req_ready) begin
            if (mem_is_load) begin
              mem_state_next = M_WAIT;
            end else begin
              mem_complete = 1'b1;
            end
          end else begin
            mem_state_next = M_REQ;
          end
        end
      end
      M_REQ: begin
        mem_req_int = 1'b1;
        if (mem_req_ready) begin
          if (mem_is_load) begin
            mem_state_next = M_WAIT;
          end else begin
            mem_complete   = 1'b1;
            mem_state_next = M_IDLE;
          end
        end
      end
      M_WAIT: begin
        if (mem_resp_valid) begin
          mem_complete   = 1'b1;
          mem_state_next = M_IDLE;
        end
      end
      default: mem_state_next = M_IDLE;
    endcase
  end

  assign mem_busy_int = mem_op & ~mem_complete;

  // ------------------------------------------------------------------
  // Mul/div occupancy FSM
  // ------------------------------------------------------------------
  logic md_start_int;
  logic md_busy_int;

`ifdef PIPE_CTRL_MULDIV_EN
  typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;

  // First EX cycle is spent in MD_IDLE, last one at cnt==0
  localparam logic [3:0] CNT_LOAD = 4'(MULDIV_LAT - 2);

  md_state_t  md_state_reg, md_state_next;
  logic [3:0] cnt_reg, cnt_next;

  // Mul/div state and countdown registers
  always_ff @(posedge clock) begin
    if (reset) begin
      md_state_reg <= MD_IDLE;
      cnt_reg      <= 4'd0;
    end else begin
      md_state_reg <= md_state_next;
      cnt_reg      <= cnt_next;
    end
  end

  // Mul/div sequencing; at cnt==0 the op is done and only MEM can hold it
  always_comb begin
    md_state_next = md_state_reg;
    cnt_next      = cnt_reg;
    md_start_int  = 1'b0;
    md_busy_int   = 1'b0;
    case (md_state_reg)
      MD_IDLE: begin
        if (ex_valid & ex_is_muldiv) begin
          md_start_int  = 1'b1;
          md_busy_int   = 1'b1;
          cnt_next      = CNT_LOAD;
          md_state_next = MD_BUSY;
        end
      end
      MD_BUSY: begin
        if (cnt_reg != 4'd0) begin
          md_busy_int = 1'b1;
          cnt_next    = cnt_reg - 4'd1;
        end else if (!mem_busy_int) begin
          md_state_next = MD_IDLE;
        end
      end
      default: md_state_next = MD_IDLE;
    endcase
  end
`else
  // Mul/div is a plain single-cycle EX op in this build
  logic unused_muldiv;
  assign unused_muldiv = ex_is_muldiv ^ (MULDIV_LAT > 1);
  assign md_start_int  = 1'b0;
  assign md_busy_int   = 1'b0;
`endif

  // ------------------------------------------------------------------
  // Hazards and prioritised output decode
  // ------------------------------------------------------------------
  logic load_use;
  logic redirect_ok;

  assign load_use = id_valid & ex_valid & ex_is_load & (ex_rd != '0) &
                    ((id_rs1_used & (id_rs1 == ex_rd)) |
                     (id_rs2_used & (id_rs2 == ex_rd)));

  // A redirect waits until EX is free to move, the BJU holds it meanwhile
  assign redirect_ok = ex_valid & redirect_valid & ~mem_busy_int & ~md_busy_int;

  // Output decode: MEM stall > mul/div stall > redirect > load-use, all quiet in reset
  always_comb begin
    stall_r1      = 1'b0;
    stall_r2      = 1'b0;
    stall_r3      = 1'b0;
    bubble_r2     = 1'b0;
    bubble_r3     = 1'b0;
    bubble_r4     = 1'b0;
    flush_r1      = 1'b0;
    redirect_fire = 1'b0;
    md_start      = 1'b0;
    md_busy       = 1'b0;
    mem_req_valid = 1'b0;
    mem_busy      = 1'b0;
    if (!reset) begin
      md_start      = md_start_int;
      md_busy       = md_busy_int;
      mem_req_valid = mem_req_int;
      mem_busy      = mem_busy_int;
      redirect_fire = redirect_ok;
      if (mem_busy_int) begin
        stall_r1  = 1'b1;
        stall_r2  = 1'b1;
        stall_r3  = 1'b1;
        bubble_r4 = 1'b1;
      end else if (md_busy_int) begin
        stall_r1  = 1'b1;
        stall_r2  = 1'b1;
        bubble_r3 = 1'b1;
      end else if (redirect_ok) begin
        flush_r1  = 1'b1;
        bubble_r2 = 1'b1;
      end else if (load_use) begin
        stall_r1  = 1'b1;
        bubble_r2 = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench for pipe_ctrl. Expected 12-bit output
// vectors are queued as stimulus is applied and compared mid-cycle.
module tb_pipe_ctrl;

  localparam int LREG_W = 5;

`ifdef PIPE_CTRL_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  // Output vector bit masks
  localparam logic [11:0] S1   = 12'h800;
  localparam logic [11:0] S2   = 12'h400;
  localparam logic [11:0] S3   = 12'h200;
  localparam logic [11:0] B2   = 12'h100;
  localparam logic [11:0] B3   = 12'h080;
  localparam logic [11:0] B4   = 12'h040;
  localparam logic [11:0] F1   = 12'h020;
  localparam logic [11:0] RF   = 12'h010;
  localparam logic [11:0] MS   = 12'h008;
  localparam logic [11:0] MB   = 12'h004;
  localparam logic [11:0] MRV  = 12'h002;
  localparam logic [11:0] MEMB = 12'h001;

  localparam logic [11:0] MEMGRP = S1 | S2 | S3 | B4 | MEMB;
  localparam logic [11:0] MDGRP  = S1 | S2 | B3 | MB;
  localparam logic [11:0] RDGRP  = RF | F1 | B2;
  localparam logic [11:0] LUGRP  = S1 | B2;
  localparam logic [11:0] NONE   = 12'h000;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic              reset;
  logic              id_valid;
  logic [LREG_W-1:0] id_rs1, id_rs2;
  logic              id_rs1_used, id_rs2_used;
  logic              ex_valid;
  logic [LREG_W-1:0] ex_rd;
  logic              ex_is_load, ex_is_muldiv, redirect_valid;
  logic              mem_valid, mem_is_load, mem_is_store;
  logic              mem_req_ready, mem_resp_valid;
  logic              stall_r1, stall_r2, stall_r3;
  logic              bubble_r2, bubble_r3, bubble_r4;
  logic              flush_r1, redirect_fire, md_start, md_busy;
  logic              mem_req_valid, mem_busy;

  pipe_ctrl #(.LREG_W(LREG_W), .MULDIV_LAT(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .id_valid       (id_valid),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_rs1_used    (id_rs1_used),
    .id_rs2_used    (id_rs2_used),
    .ex_valid       (ex_valid),
    .ex_rd          (ex_rd),
    .ex_is_load     (ex_is_load),
    .ex_is_muldiv   (ex_is_muldiv),
    .redirect_valid (redirect_valid),
    .mem_valid      (mem_valid),
    .mem_is_load    (mem_is_load),
    .mem_is_store   (mem_is_store),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .stall_r1       (stall_r1),
    .stall_r2       (stall_r2),
    .stall_r3       (stall_r3),
    .bubble_r2      (bubble_r2),
    .bubble_r3      (bubble_r3),
    .bubble_r4      (bubble_r4),
    .flush_r1       (flush_r1),
    .redirect_fire  (redirect_fire),
    .md_start       (md_start),
    .md_busy        (md_busy),
    .mem_req_valid  (mem_req_valid),
    .mem_busy       (mem_busy)
  );

  logic [11:0] obs;
  assign obs = {stall_r1, stall_r2, stall_r3, bubble_r2, bubble_r3, bubble_r4,
                flush_r1, redirect_fire, md_start, md_busy, mem_req_valid, mem_busy};

  typedef struct {
    string       tag;
    logic [11:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check_vec(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %03h expected %03h", tag, got, exp);
    end else begin
      $display("vec %0d %s: got %03h expected %03h ok", n_vec, tag, got, exp);
    end
  endtask

  // Queue the expectation for the inputs just driven, check mid-cycle,
  // then move to just after the next rising edge
  task automatic step(input string tag, input logic [11:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
    @(negedge clock);
    e = sb_q.pop_front();
    check_vec(e.tag, obs, e.exp);
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    id_valid       = 1'b0;
    id_rs1         = '0;
    id_rs2         = '0;
    id_rs1_used    = 1'b0;
    id_rs2_used    = 1'b0;
    ex_valid       = 1'b0;
    ex_rd          = '0;
    ex_is_load     = 1'b0;
    ex_is_muldiv   = 1'b0;
    redirect_valid = 1'b0;
    mem_valid      = 1'b0;
    mem_is_load    = 1'b0;
    mem_is_store   = 1'b0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
  endtask

  initial begin
    clear_inputs();

    // Reset with a load pending in MEM
    reset       = 1'b1;
    mem_valid   = 1'b1;
    mem_is_load = 1'b1;
    for (int i = 0; i < 3; i++) step("reset", NONE);
    reset         = 1'b0;
    mem_req_ready = 1'b1;
    step("rst_release_req", MRV | MEMGRP);
    mem_req_ready = 1'b0;
    step("rst_load_wait", MEMGRP);
    mem_resp_valid = 1'b1;
    step("rst_load_resp", NONE);
    clear_inputs();
    step("idle", NONE);

    // Reset mid-load: the stale response must be ignored afterwards
    mem_valid     = 1'b1;
    mem_is_load   = 1'b1;
    mem_req_ready = 1'b1;
    step("abort_accept", MRV | MEMGRP);
    reset = 1'b1;
    step("abort_reset", NONE);
    reset          = 1'b0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    step("abort_stale_resp", MRV | MEMGRP);
    mem_resp_valid = 1'b0;
    mem_req_ready  = 1'b1;
    step("abort_reissue", MRV | MEMGRP);
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    step("abort_resp", NONE);
    clear_inputs();

    // Load-use hazards
    ex_valid    = 1'b1;
    ex_is_load  = 1'b1;
    ex_rd       = 5'd5;
    id_valid    = 1'b1;
    id_rs1      = 5'd3;
    id_rs1_used = 1'b1;
    id_rs2      = 5'd5;
    id_rs2_used = 1'b1;
    step("lu_rs2", LUGRP);
    ex_is_load = 1'b0;
    ex_rd      = 5'd9;
    step("lu_cleared", NONE);
    ex_is_load = 1'b1;
    ex_rd      = 5'd0;
    id_rs2     = 5'd0;
    step("lu_x0", NONE);
    ex_rd       = 5'd3;
    id_rs1_used = 1'b0;
    step("lu_rs1_unused", NONE);
    id_rs1_used = 1'b1;
    step("lu_rs1", LUGRP);
    id_valid = 1'b0;
    step("lu_id_invalid", NONE);
    clear_inputs();

    // Load in MEM: 2 ready-low cycles, response 3 cycles after accept,
    // with a redirect waiting in EX the whole time
    ex_valid       = 1'b1;
    redirect_valid = 1'b1;
    mem_valid      = 1'b1;
    mem_is_load    = 1'b1;
    step("ld_req1", MRV | MEMGRP);
    step("ld_req2", MRV | MEMGRP);
    mem_req_ready = 1'b1;
    step("ld_accept", MRV | MEMGRP);
    mem_req_ready = 1'b0;
    step("ld_wait1", MEMGRP);
    step("ld_wait2", MEMGRP);
    mem_resp_valid = 1'b1;
    step("ld_resp_redirect", RDGRP);
    clear_inputs();

    // Stores
    mem_valid     = 1'b1;
    mem_is_store  = 1'b1;
    mem_req_ready = 1'b1;
    step("st_fast1", MRV);
    step("st_fast2", MRV);
    mem_req_ready = 1'b0;
    step("st_slow_req", MRV | MEMGRP);
    mem_req_ready = 1'b1;
    step("st_slow_accept", MRV);
    clear_inputs();
    step("st_idle", NONE);

    // Mul/div occupancy
    ex_valid     = 1'b1;
    ex_is_muldiv = 1'b1;
    step("md_c1", MD_EN ? (MS | MDGRP) : NONE);
    step("md_c2", MD_EN ? MDGRP : NONE);
    step("md_c3", MD_EN ? MDGRP : NONE);
    step("md_c4", NONE);
    ex_is_muldiv = 1'b0;
    step("md_next", NONE);
    clear_inputs();

    // Redirect held while mul/div has 2 stall cycles left, plus load-use
    ex_valid     = 1'b1;
    ex_is_muldiv = 1'b1;
    step("rmd_c1", MD_EN ? (MS | MDGRP) : NONE);
    redirect_valid = 1'b1;
    ex_is_load     = 1'b1;
    ex_rd          = 5'd7;
    id_valid       = 1'b1;
    id_rs1         = 5'd7;
    id_rs1_used    = 1'b1;
    step("rmd_c2", MD_EN ? MDGRP : RDGRP);
    step("rmd_c3", MD_EN ? MDGRP : RDGRP);
    step("rmd_c4_fire", RDGRP);
    clear_inputs();
    step("rmd_idle", NONE);

    // Load waiting in MEM while mul/div finishes in EX
    ex_valid      = 1'b1;
    ex_is_muldiv  = 1'b1;
    mem_valid     = 1'b1;
    mem_is_load   = 1'b1;
    mem_req_ready = 1'b1;
    step("ov_c1", MD_EN ? (MRV | MEMGRP | MS | MB) : (MRV | MEMGRP));
    mem_req_ready = 1'b0;
    step("ov_c2", MD_EN ? (MEMGRP | MB) : MEMGRP);
    step("ov_c3", MD_EN ? (MEMGRP | MB) : MEMGRP);
    step("ov_c4", MEMGRP);
    step("ov_c5", MEMGRP);
    mem_resp_valid = 1'b1;
    step("ov_resp", NONE);
    mem_resp_valid = 1'b0;
    mem_valid      = 1'b0;
    mem_is_load    = 1'b0;
    step("ov_new_md1", MD_EN ? (MS | MDGRP) : NONE);
    step("ov_new_md2", MD_EN ? MDGRP : NONE);
    step("ov_new_md3", MD_EN ? MDGRP : NONE);
    step("ov_new_md4", NONE);
    clear_inputs();
    step("final_idle", NONE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline sequencer for the five-stage in-order backend. It drives the stall and bubble controls of the four inter-stage pipeline registers: IF/ID (R1), ID/EX (R2), EX/MEM (R3) and MEM/WB (R4). It owns three pieces of control:
- a multi-cycle mul/div occupancy FSM,
- a load/store memory handshake FSM,
- load-use and branch-redirect hazard resolution.

## Interface
Parameters:
- LREG_W, 5, logical register index width
- MULDIV_LAT, 4, total cycles a mul/div instruction occupies EX (legal range ≥2, ≤16)

Ports. Clock and reset: one clock; reset is synchronous and active-high.
- clock  in  1  core clock
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  R1 output valid
- id_rs1, id_rs2  in  LREG_W  ID source registers
- id_rs1_used, id_rs2_used  in  1  source actually read
- ex_valid  in  1  R2 output valid
- ex_rd  in  LREG_W  EX destination
- ex_is_load  in  1  EX instruction is a load
- ex_is_muldiv  in  1  EX instruction is mul/div
- redirect_valid  in  1  BJU taken-branch/jump mispredict in EX
- mem_valid  in  1  R3 output valid
- mem_is_load, mem_is_store  in  1  MEM-stage op kind
- mem_req_ready  in  1  D-side accepts request
- mem_resp_valid  in  1  load data returned
- stall_r1, stall_r2, stall_r3  out  1  hold R1/R2/R3; stall_r1 also holds PC
- bubble_r2, bubble_r3, bubble_r4  out  1  register loads valid=0
- flush_r1  out  1  R1 loads valid=0
- redirect_fire  out  1  redirect accepted; PC takes target
- md_start  out  1  one-cycle start pulse to mul/div unit
- md_busy  out  1  mul/div stall active
- mem_req_valid  out  1  D-side request
- mem_busy  out  1  MEM stall active

## Operation
- Mul/div FSM has states MD_IDLE and MD_BUSY, with a 4-bit down-counter cnt.
  - MD_IDLE with ex_valid & ex_is_muldiv: pulse md_start, load cnt=MULDIV_LAT-2, go to MD_BUSY.
  - MD_BUSY: cnt decrements while nonzero.
  - MD_BUSY with cnt==0 and ~mem_busy: return to MD_IDLE.
  - md_busy = (MD_IDLE & ex_valid & ex_is_muldiv) | (MD_BUSY & cnt!=0).
- Memory FSM has states M_IDLE, M_REQ and M_WAIT. Define op = mem_valid & (mem_is_load|mem_is_store).
  - mem_req_valid = (M_IDLE & op) | M_REQ.
  - On accept (mem_req_valid & mem_req_ready): a store completes that cycle and the FSM goes to M_IDLE; a load goes to M_WAIT.
  - M_IDLE & op & ~mem_req_ready: go to M_REQ.
  - M_WAIT & mem_resp_valid: complete and go to M_IDLE.
  - mem_resp_valid is ignored outside M_WAIT.
  - mem_busy = op & ~complete.
- Hazard terms:
  - load_use = id_valid & ex_valid & ex_is_load & ex_rd!=0 & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
  - redirect_fire = ex_valid & redirect_valid & ~mem_busy & ~md_busy.
- Output priority, highest first; all unlisted outputs are 0:
  1. mem_busy: stall_r1, stall_r2, stall_r3, bubble_r4.
  2. md_busy: stall_r1, stall_r2, bubble_r3.
  3. redirect_fire: flush_r1, bubble_r2 (squashes wrong-path IF and ID). It takes precedence over load_use.
  4. load_use: stall_r1, bubble_r2.
- No register is ever stalled and bubbled in the same cycle.

## Timing
- Reset:
  - States go to MD_IDLE/M_IDLE and cnt=0.
  - While reset=1, every output is 0.
  - A reset mid-transaction abandons it; a later mem_resp_valid is ignored.
- Mul/div: the instruction occupies EX for exactly MULDIV_LAT cycles, of which MULDIV_LAT-1 carry md_busy. It advances on the cycle cnt==0, unless mem_busy.
- If mem_busy overlaps a mul/div, the counter keeps running. The FSM waits in MD_BUSY with cnt==0 until MEM frees, with no extra md_busy cycles.
- Store with ready already high: zero stall cycles.
- Load: stall cycles = request-wait cycles + cycles until resp. It advances in the resp cycle.
- Load-use: exactly one bubble, since the load leaves EX the next cycle.
- Redirect: combinational same-cycle flush. It is deferred, not dropped, while EX is stalled; the BJU keeps redirect_valid high.
- All decision outputs are combinational from inputs and state. Only FSM state and cnt are registered.

## Configuration
- PIPE_CTRL_MULDIV_EN defined: the mul/div FSM is present as above.
- PIPE_CTRL_MULDIV_EN undefined:
  - FSM and counter are removed.
  - md_busy and md_start are tied 0.
  - mul/div is treated as a single-cycle EX op.
  - MULDIV_LAT is unused.

## Test plan
- Reset held for 3 cycles with mem_valid=1 and mem_is_load=1 → all outputs 0. After release, mem_req_valid=1 in the first cycle.
- Load in EX with ex_rd=5, ID reads rs2=5 → one cycle of stall_r1=1 and bubble_r2=1, then no hazard. Repeat with ex_rd=0 → no stall.
- MULDIV_LAT=4 with mul/div entering EX → md_start for one cycle, md_busy for 3 cycles, bubble_r3 for 3 cycles, EX advances on cycle 4. With the macro undefined → zero stalls.
- Load in MEM with mem_req_ready low for 2 cycles, resp 3 cycles after accept → mem_busy for 5 cycles, bubble_r4 each of those cycles, advance in the resp cycle. A store with ready high → mem_busy never asserts.
- redirect_valid while the mul/div has 2 stall cycles left → redirect_fire stays 0 for 2 cycles, then fires with flush_r1=1 and bubble_r2=1. A simultaneous load_use in that cycle → no stall_r1.
- Load in M_WAIT with a mul/div finishing in EX → MD_BUSY holds cnt==0 until resp. Both then advance together with no additional md_busy.
